resource_grant_ctrl: RTL

- Responder end of the two-requester req/grant protocol used by the pipelines to share one resource.
- Arbitrates between requester 1 and requester 2 with round-robin ordering and a bounded hold time.
- Steers the granted requester's data into the shared resource and tags each issued transaction.
- Routes each resource result back to the requester that issued it, with a per-requester valid and flush-driven squashing of in-flight work.

---
 rtl/resource_grant_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/resource_grant_ctrl.sv
// Responder side of the two-requester req/grant protocol: round-robin arbitration with
// bounded hold, issue steering into the shared resource, and tagged, flushable result return.
module resource_grant_ctrl #(
  parameter int DATA_W   = 32,
  parameter int RES_LAT  = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_1,
  input  logic              req_2,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              grant_1,
  output logic              grant_2,
  output logic [DATA_W-1:0] res_in,
  output logic              res_in_valid,
  input  logic [DATA_W-1:0] res_out,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_valid_1,
  output logic              rsp_valid_2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [3:0]           hold_cnt_r;
  logic [3:0]           hold_nxt_s;
  logic                 last_2_r;
  logic                 grant_1_r;
  logic                 grant_2_r;
  logic                 ereq_1_s;
  logic                 ereq_2_s;
  logic                 res_in_valid_s;
  logic [DATA_W-1:0]    res_in_s;
  logic [RES_LAT-1:0]   tag_valid_r;
  logic [RES_LAT-1:0]   tag_id_r;
  logic [RES_LAT-1:0]   kill_s;

  assign ereq_1_s = req_1 & ~flush_1;
  assign ereq_2_s = req_2 & ~flush_2;

  // Next owner and hold counter; hold_nxt_s defaults to a clear on every owner change.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = 4'd0;
    case (state_r)
      IDLE: begin
        if (ereq_1_s && ereq_2_s) begin
          state_nxt_s = last_2_r ? OWN1 : OWN2;
        end else if (ereq_1_s) begin
          state_nxt_s = OWN1;
        end else if (ereq_2_s) begin
          state_nxt_s = OWN2;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN1: begin
        if (!ereq_1_s) begin
          state_nxt_s = ereq_2_s ? OWN2 : IDLE;
        end else if (ereq_2_s && (hold_cnt_r == HOLD_LAST)) begin
          state_nxt_s = OWN2;
        end else begin
          state_nxt_s = OWN1;
          hold_nxt_s  = !ereq_2_s ? 4'd0 :
                        (hold_cnt_r == HOLD_LAST) ? HOLD_LAST : hold_cnt_r + 4'd1;
        end
      end
      OWN2: begin
        if (!ereq_2_s) begin
          state_nxt_s = ereq_1_s ? OWN1 : IDLE;
        end else if (ereq_1_s && (hold_cnt_r == HOLD_LAST)) begin
          state_nxt_s = OWN1;
        end else begin
          state_nxt_s = OWN2;
          hold_nxt_s  = !ereq_1_s ? 4'd0 :
                        (hold_cnt_r == HOLD_LAST) ? HOLD_LAST : hold_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Owner state, registered grants, hold counter and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= 4'd0;
      last_2_r   <= 1'b1;
      grant_1_r  <= 1'b0;
      grant_2_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      grant_1_r  <= (state_nxt_s == OWN1);
      grant_2_r  <= (state_nxt_s == OWN2);
      if (state_nxt_s == OWN1) begin
        last_2_r <= 1'b0;
      end else if (state_nxt_s == OWN2) begin
        last_2_r <= 1'b1;
      end else begin
        last_2_r <= last_2_r;
      end
    end
  end

  // Issue steering: the owner's operand goes out whenever it still has an effective request.
  always_comb begin
    res_in_valid_s = (grant_1_r & ereq_1_s) | (grant_2_r & ereq_2_s);
    if (grant_1_r) begin
      res_in_s = req_data_1;
    end else if (grant_2_r) begin
      res_in_s = req_data_2;
    end else begin
      res_in_s = '0;
    end
  end

  // Tag id 0 is requester 1, id 1 is requester 2; a flush kills matching entries in flight.
  assign kill_s = (tag_id_r & {RES_LAT{flush_2}}) | (~tag_id_r & {RES_LAT{flush_1}});

  // Tag pipe tracking which requester owns each result still inside the resource.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid_r <= '0;
      tag_id_r    <= '0;
    end else begin
      tag_valid_r[0] <= res_in_valid_s;
      tag_id_r[0]    <= grant_2_r;
      for (int i = 1; i < RES_LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1] & ~kill_s[i-1];
        tag_id_r[i]    <= tag_id_r[i-1];
      end
    end
  end

  assign grant_1      = grant_1_r;
  assign grant_2      = grant_2_r;
  assign res_in       = res_in_s;
  assign res_in_valid = res_in_valid_s;
  assign rsp_data     = res_out;
  assign rsp_valid_1  = tag_valid_r[RES_LAT-1] & ~tag_id_r[RES_LAT-1] & ~kill_s[RES_LAT-1];
  assign rsp_valid_2  = tag_valid_r[RES_LAT-1] &  tag_id_r[RES_LAT-1] & ~kill_s[RES_LAT-1];

endmodule
